// File: rtl/alu_pkg.sv
// Shared constants and types for the alu_mdu execution unit.
// Op indices are bit positions in the one-hot alu_op vector.
package alu_pkg;

    localparam int ALU_OP_W = 19;

    localparam int OP_ADD   = 0;
    localparam int OP_SUB   = 1;
    localparam int OP_SLT   = 2;
    localparam int OP_SLTU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_NOR   = 5;
    localparam int OP_OR    = 6;
    localparam int OP_XOR   = 7;
    localparam int OP_SLL   = 8;
    localparam int OP_SRL   = 9;
    localparam int OP_SRA   = 10;
    localparam int OP_LUI   = 11;
    localparam int OP_MUL   = 12;
    localparam int OP_MULH  = 13;
    localparam int OP_MULHU = 14;
    localparam int OP_DIV   = 15;
    localparam int OP_DIVU  = 16;
    localparam int OP_MOD   = 17;
    localparam int OP_MODU  = 18;

    // Shift-amount width at the default 32-bit datapath.
    localparam int SHW = $clog2(32);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Works on magnitudes; the sign fix-up is applied to the final iteration's value.
module alu_muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             clear,
    input  logic             div_sel,
    input  logic             signed_sel,
    input  logic             high_sel,
    input  logic             rem_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, want_high, want_rem, res_neg, rem_neg;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, shifted;
    logic               ge;
    logic [WIDTH-1:0]   rem_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem, quo_fix, rem_fix;

    assign a_neg = signed_sel & a[WIDTH-1];
    assign b_neg = signed_sel & b[WIDTH-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // Multiply keeps the multiplier in the low half and shifts right; divide
    // keeps the dividend/quotient in the low half and shifts left.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge       = shifted >= {1'b0, opnd};
        rem_step = ge ? WIDTH'(shifted - {1'b0, opnd}) : shifted[WIDTH-1:0];
        if (is_div)
            acc_next = {rem_step, acc[WIDTH-2:0], ge};
        else
            acc_next = {sum, acc[WIDTH-1:1]};
    end

    always_comb begin
        prod_fix = res_neg ? -acc_next : acc_next;
        quo      = acc_next[WIDTH-1:0];
        rem      = acc_next[2*WIDTH-1:WIDTH];
        quo_fix  = res_neg ? -quo : quo;
        rem_fix  = rem_neg ? -rem : rem;
        if (is_div)
            result = want_rem ? rem_fix : quo_fix;
        else
            result = want_high ? prod_fix[2*WIDTH-1:WIDTH] : prod_fix[WIDTH-1:0];
    end

    assign done = busy && (count == LAST);

    // Divide by zero must yield an all-ones quotient, so its negation is suppressed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy      <= 1'b0;
            count     <= '0;
            acc       <= '0;
            opnd      <= '0;
            is_div    <= 1'b0;
            want_high <= 1'b0;
            want_rem  <= 1'b0;
            res_neg   <= 1'b0;
            rem_neg   <= 1'b0;
        end else if (clear) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            busy      <= 1'b1;
            count     <= '0;
            is_div    <= div_sel;
            want_high <= high_sel;
            want_rem  <= rem_sel;
            opnd      <= div_sel ? b_mag : a_mag;
            acc       <= {{WIDTH{1'b0}}, (div_sel ? a_mag : b_mag)};
            res_neg   <= (a_neg ^ b_neg) & (~div_sel | (b != '0));
            rem_neg   <= a_neg;
        end else if (busy) begin
            acc <= acc_next;
            if (done) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked EXE-stage unit: single-cycle ALU plus iterative mul/div/rem,
// with a registered result held until the consumer accepts it.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [WIDTH-1:0]    alu_src1,
    input  logic [WIDTH-1:0]    alu_src2,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    alu_result,
    output logic                alu_overflow
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic             accept, is_iter;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] add_sum;
    logic [WIDTH:0]   sub_full;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] alu_value;
    logic             alu_ovf;
    logic             mdu_start, mdu_busy, mdu_done;
    logic [WIDTH-1:0] mdu_result;

    assign in_ready = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign is_iter  = |alu_op[OP_MODU:OP_MUL];

    assign shamt    = alu_src1[SHW-1:0];
    assign add_sum  = alu_src1 + alu_src2;
    assign sub_full = {1'b0, alu_src1} + {1'b0, ~alu_src2} + (WIDTH+1)'(1);
    assign add_ovf  = (alu_src1[WIDTH-1] == alu_src2[WIDTH-1]) && (add_sum[WIDTH-1] != alu_src1[WIDTH-1]);
    assign sub_ovf  = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) && (sub_full[WIDTH-1] != alu_src1[WIDTH-1]);

    always_comb begin
        alu_value = '0;
        alu_ovf   = 1'b0;
        case (1'b1)
            alu_op[OP_ADD]:  begin alu_value = add_sum; alu_ovf = add_ovf; end
            alu_op[OP_SUB]:  begin alu_value = sub_full[WIDTH-1:0]; alu_ovf = sub_ovf; end
            alu_op[OP_SLT]:  alu_value = {{(WIDTH-1){1'b0}}, sub_full[WIDTH-1] ^ sub_ovf};
            alu_op[OP_SLTU]: alu_value = {{(WIDTH-1){1'b0}}, ~sub_full[WIDTH]};
            alu_op[OP_AND]:  alu_value = alu_src1 & alu_src2;
            alu_op[OP_NOR]:  alu_value = ~(alu_src1 | alu_src2);
            alu_op[OP_OR]:   alu_value = alu_src1 | alu_src2;
            alu_op[OP_XOR]:  alu_value = alu_src1 ^ alu_src2;
            alu_op[OP_SLL]:  alu_value = alu_src2 << shamt;
            alu_op[OP_SRL]:  alu_value = alu_src2 >> shamt;
            alu_op[OP_SRA]:  alu_value = $signed(alu_src2) >>> shamt;
            alu_op[OP_LUI]:  alu_value = {alu_src2[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            default: ;
        endcase
    end

    assign mdu_start = accept && is_iter;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .resetn     (resetn),
        .start      (mdu_start),
        .clear      (flush),
        .div_sel    (|alu_op[OP_MODU:OP_DIV]),
        .signed_sel (alu_op[OP_MULH] | alu_op[OP_DIV] | alu_op[OP_MOD]),
        .high_sel   (alu_op[OP_MULH] | alu_op[OP_MULHU]),
        .rem_sel    (alu_op[OP_MOD] | alu_op[OP_MODU]),
        .a          (alu_src1),
        .b          (alu_src2),
        .busy       (mdu_busy),
        .done       (mdu_done),
        .result     (mdu_result)
    );

    // Flush wins over acceptance and completion; a DONE state can hand off
    // directly to the next op in the same cycle the result is taken.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            out_valid    <= 1'b0;
            alu_result   <= '0;
            alu_overflow <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        if (is_iter) begin
                            state     <= S_BUSY;
                            out_valid <= 1'b0;
                        end else begin
                            state        <= S_DONE;
                            out_valid    <= 1'b1;
                            alu_result   <= alu_value;
                            alu_overflow <= alu_ovf;
                        end
                    end else if ((state == S_DONE) && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (mdu_busy && mdu_done) begin
                        state        <= S_DONE;
                        out_valid    <= 1'b1;
                        alu_result   <= mdu_result;
                        alu_overflow <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed-vector bench for alu_mdu at WIDTH=32 (instance a) and WIDTH=16 (instance b).
module tb_alu_mdu;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic        a_in_valid = 1'b0, a_in_ready, a_flush = 1'b0, a_out_valid, a_out_ready = 1'b0, a_ovf;
    logic [18:0] a_op = '0;
    logic [31:0] a_src1 = '0, a_src2 = '0, a_result;
    logic        b_in_valid = 1'b0, b_in_ready, b_flush = 1'b0, b_out_valid, b_out_ready = 1'b0, b_ovf;
    logic [18:0] b_op = '0;
    logic [15:0] b_src1 = '0, b_src2 = '0, b_result;

    alu_mdu #(.WIDTH(32)) dut_a (
        .clk(clk), .resetn(resetn), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .alu_op(a_op), .alu_src1(a_src1), .alu_src2(a_src2), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .alu_result(a_result), .alu_overflow(a_ovf)
    );

    alu_mdu #(.WIDTH(16)) dut_b (
        .clk(clk), .resetn(resetn), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .alu_op(b_op), .alu_src1(b_src1), .alu_src2(b_src2), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .alu_result(b_result), .alu_overflow(b_ovf)
    );

    function automatic logic [18:0] oh(input int idx);
        logic [18:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    task automatic run_single32(input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2,
                                output logic [31:0] res, output logic ovf, output logic vld);
        a_op = op; a_src1 = s1; a_src2 = s2; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        res = a_result; ovf = a_ovf; vld = a_out_valid;
    endtask

    task automatic run_single16(input logic [18:0] op, input logic [15:0] s1, input logic [15:0] s2,
                                output logic [15:0] res, output logic ovf, output logic vld);
        b_op = op; b_src1 = s1; b_src2 = s2; b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        res = b_result; ovf = b_ovf; vld = b_out_valid;
    endtask

    // Operand inputs are scrambled after acceptance to confirm they were captured.
    task automatic run_iter32(input logic [18:0] op, input logic [31:0] s1, input logic [31:0] s2,
                              output logic [31:0] res, output int lat, output logic rdy_seen);
        a_op = op; a_src1 = s1; a_src2 = s2; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_op = oh(OP_ADD); a_src1 = 32'h1357_9BDF; a_src2 = 32'h0;
        lat = 0; rdy_seen = 1'b0;
        while (!a_out_valid && lat < 200) begin
            rdy_seen = rdy_seen | a_in_ready;
            @(posedge clk); #1;
            lat++;
        end
        res = a_result;
    endtask

    task automatic run_iter16(input logic [18:0] op, input logic [15:0] s1, input logic [15:0] s2,
                              output logic [15:0] res, output int lat);
        b_op = op; b_src1 = s1; b_src2 = s2; b_in_valid = 1'b1; b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_src1 = 16'h0; b_src2 = 16'h0;
        lat = 0;
        while (!b_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = b_result;
    endtask

    task automatic test_reset();
        #2 resetn = 1'b0;
        #5;
        compared++; if (a_in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", a_in_ready); end
        compared++; if (a_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid); end
        compared++; if (a_result !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 0", a_result); end
        compared++; if (a_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", a_ovf); end
        compared++; if (b_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset16_out_valid: got %b expected 0", b_out_valid); end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        a_op = oh(OP_ADD); a_src1 = 32'h7FFF_FFFF; a_src2 = 32'h1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        compared++; if (a_in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_idle_ready: got %b expected 1", a_in_ready); end
        @(posedge clk); #1;
        compared++; if (a_out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_add_valid: got %b expected 1", a_out_valid); end
        compared++; if (a_result !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL b2b_add_result: got %h expected 80000000", a_result); end
        compared++; if (a_ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_add_overflow: got %b expected 1", a_ovf); end
        compared++; if (a_in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_done_ready: got %b expected 1", a_in_ready); end
        a_op = oh(OP_SLTU); a_src1 = 32'h1; a_src2 = 32'h2;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        compared++; if (a_out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_sltu_valid: got %b expected 1", a_out_valid); end
        compared++; if (a_result !== 32'h1) begin mismatched++; $display("[TB] FAIL b2b_sltu_result: got %h expected 1", a_result); end
        compared++; if (a_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_sltu_overflow: got %b expected 0", a_ovf); end
        @(posedge clk); #1;
        compared++; if (a_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_drain_valid: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_multiply();
        logic [31:0] res;
        int lat;
        logic rdy;
        run_iter32(oh(OP_MULH), 32'hFFFF_FFFD, 32'h5, res, lat, rdy);
        compared++; if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL mulh_result: got %h expected ffffffff", res); end
        // Accepted at the edge closing cycle t; valid in cycle t+33, i.e. 32 edges later.
        compared++; if (lat !== 32) begin mismatched++; $display("[TB] FAIL mulh_latency: got %0d edges expected 32", lat); end
        compared++; if (rdy !== 1'b0) begin mismatched++; $display("[TB] FAIL mulh_busy_ready: got %b expected 0", rdy); end
        run_iter32(oh(OP_MUL), 32'h1234_5678, 32'h10, res, lat, rdy);
        compared++; if (res !== 32'h2345_6780) begin mismatched++; $display("[TB] FAIL mul_result: got %h expected 23456780", res); end
        run_iter32(oh(OP_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, rdy);
        compared++; if (res !== 32'hFFFF_FFFE) begin mismatched++; $display("[TB] FAIL mulhu_result: got %h expected fffffffe", res); end
    endtask

    task automatic test_divide();
        logic [31:0] res;
        int lat;
        logic rdy;
        run_iter32(oh(OP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rdy);
        compared++; if (res !== 32'h8000_0000) begin mismatched++; $display("[TB] FAIL div_ovf_result: got %h expected 80000000", res); end
        compared++; if (lat !== 32) begin mismatched++; $display("[TB] FAIL div_latency: got %0d edges expected 32", lat); end
        run_iter32(oh(OP_MOD), 32'h8000_0000, 32'hFFFF_FFFF, res, lat, rdy);
        compared++; if (res !== 32'h0) begin mismatched++; $display("[TB] FAIL mod_ovf_result: got %h expected 0", res); end
        run_iter32(oh(OP_DIVU), 32'h7, 32'h0, res, lat, rdy);
        compared++; if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL divu_zero_result: got %h expected ffffffff", res); end
        run_iter32(oh(OP_MODU), 32'h7, 32'h0, res, lat, rdy);
        compared++; if (res !== 32'h7) begin mismatched++; $display("[TB] FAIL modu_zero_result: got %h expected 7", res); end
        run_iter32(oh(OP_DIV), 32'hFFFF_FFF9, 32'h0, res, lat, rdy);
        compared++; if (res !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL div_neg_zero_result: got %h expected ffffffff", res); end
        run_iter32(oh(OP_MOD), 32'hFFFF_FFF9, 32'h0, res, lat, rdy);
        compared++; if (res !== 32'hFFFF_FFF9) begin mismatched++; $display("[TB] FAIL mod_neg_zero_result: got %h expected fffffff9", res); end
    endtask

    task automatic test_width16();
        logic [15:0] res;
        logic ovf, vld;
        int lat;
        run_single16(oh(OP_SRA), 16'd15, 16'h8000, res, ovf, vld);
        compared++; if (res !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL w16_sra_result: got %h expected ffff", res); end
        compared++; if (vld !== 1'b1) begin mismatched++; $display("[TB] FAIL w16_sra_valid: got %b expected 1", vld); end
        run_single16(oh(OP_SRL), 16'd15, 16'h8000, res, ovf, vld);
        compared++; if (res !== 16'h0001) begin mismatched++; $display("[TB] FAIL w16_srl_result: got %h expected 0001", res); end
        run_single16(oh(OP_LUI), 16'h0, 16'h00AB, res, ovf, vld);
        compared++; if (res !== 16'hAB00) begin mismatched++; $display("[TB] FAIL w16_lui_result: got %h expected ab00", res); end
        run_single16(oh(OP_SLT), 16'hFFFF, 16'h0001, res, ovf, vld);
        compared++; if (res !== 16'h0001) begin mismatched++; $display("[TB] FAIL w16_slt_result: got %h expected 0001", res); end
        run_single16(oh(OP_ADD), 16'h7FFF, 16'h0001, res, ovf, vld);
        compared++; if (res !== 16'h8000 || ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL w16_add_ovf: got %h/%b expected 8000/1", res, ovf); end
        run_single16(oh(OP_SUB), 16'h0005, 16'h0007, res, ovf, vld);
        compared++; if (res !== 16'hFFFE || ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL w16_sub: got %h/%b expected fffe/0", res, ovf); end
        run_iter16(oh(OP_DIV), 16'hFFF9, 16'h0002, res, lat);
        compared++; if (res !== 16'hFFFD) begin mismatched++; $display("[TB] FAIL w16_div_result: got %h expected fffd", res); end
        compared++; if (lat !== 16) begin mismatched++; $display("[TB] FAIL w16_div_latency: got %0d edges expected 16", lat); end
        run_iter16(oh(OP_MOD), 16'hFFF9, 16'h0002, res, lat);
        compared++; if (res !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL w16_mod_result: got %h expected ffff", res); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic stable;
        stable = 1'b1;
        a_op = oh(OP_XOR); a_src1 = 32'hA5A5_A5A5; a_src2 = 32'hFFFF_0000; a_in_valid = 1'b1; a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_op = oh(OP_ADD); a_src1 = 32'h1; a_src2 = 32'h1;
        compared++; if (a_result !== 32'h5A5A_A5A5) begin mismatched++; $display("[TB] FAIL bp_xor_result: got %h expected 5a5aa5a5", a_result); end
        for (int i = 0; i < 5; i++) begin
            if (a_out_valid !== 1'b1 || a_result !== 32'h5A5A_A5A5 || a_in_ready !== 1'b0) stable = 1'b0;
            @(posedge clk); #1;
        end
        compared++; if (stable !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold: got %b expected 1", stable); end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        compared++; if (a_out_valid !== 1'b1 || a_result !== 32'h2) begin mismatched++; $display("[TB] FAIL bp_release: got %b/%h expected 1/00000002", a_out_valid, a_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic ovf, vld, seen;
        a_op = oh(OP_DIVU); a_src1 = 32'd100; a_src2 = 32'd7; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 a_flush = 1'b1;
        @(posedge clk); #1;
        a_flush = 1'b0;
        compared++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_idle: got valid %b ready %b expected 0/1", a_out_valid, a_in_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | a_out_valid;
            @(posedge clk); #1;
        end
        compared++; if (seen !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_no_result: got %b expected 0", seen); end
        run_single32(oh(OP_ADD), 32'd2, 32'd3, res, ovf, vld);
        compared++; if (res !== 32'd5 || vld !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_next_add: got %h/%b expected 00000005/1", res, vld); end
        a_op = oh(OP_ADD); a_src1 = 32'd4; a_src2 = 32'd4; a_in_valid = 1'b1; a_flush = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_flush = 1'b0;
        compared++; if (a_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_blocks_accept: got %b expected 0", a_out_valid); end
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] res;
        logic ovf, vld, seen;
        run_single32(oh(OP_ADD), 32'h7FFF_FFFF, 32'h1, res, ovf, vld);
        compared++; if (ovf !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_pre_overflow: got %b expected 1", ovf); end
        a_op = oh(OP_MUL); a_src1 = 32'd3; a_src2 = 32'd4; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        compared++; if (a_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", a_out_valid); end
        compared++; if (a_in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", a_in_ready); end
        compared++; if (a_result !== 32'h0) begin mismatched++; $display("[TB] FAIL rst_mid_result: got %h expected 0", a_result); end
        compared++; if (a_ovf !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_overflow: got %b expected 0", a_ovf); end
        @(negedge clk); resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | a_out_valid;
        end
        compared++; if (seen !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_mid_no_result: got %b expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_multiply();
        test_divide();
        test_width16();
        test_backpressure();
        test_flush();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked execution unit: the full single-cycle integer operation set plus iterative multiply, divide and remainder at a configurable datapath width, with a registered result. It sits in the EXE stage between the ID/EXE and EXE/MEM pipeline registers. It accepts one operation at a time through valid/ready handshakes, holds its result until the consumer takes it, and supports a pipeline flush.

## Interface
- WIDTH, 32, datapath width; even, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept this cycle.
- alu_op  in  19  one-hot opcode.
  - Bits 0–11: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - Bits 12–18: mul, mulh, mulhu, div, divu, mod, modu.
- alu_src1  in  WIDTH  operand 1; shift amount in [SHW-1:0].
- alu_src2  in  WIDTH  operand 2.
- flush  in  1  cancels any accepted, undelivered operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- alu_result  out  WIDTH  registered result.
- alu_overflow  out  1  registered signed add/sub overflow; 0 for all other ops.

## Operation
- Accept when in_valid & in_ready. Operands and op are captured at acceptance; later input changes are ignored.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterative op in progress; in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready, giving a back-to-back path.
- Transitions:
  - IDLE/DONE → DONE on accepting a single-cycle op or a zero op.
  - IDLE/DONE → BUSY on accepting ops 12–18.
  - BUSY → DONE when the count reaches WIDTH-1.
  - DONE → IDLE when out_ready is high and no new op is accepted.
- Single-cycle ops match the 32-bit ALU semantics, generalised:
  - lui = {src2[WIDTH/2-1:0], WIDTH/2 zeros}.
  - Shifts use src1[SHW-1:0].
  - slt = sign(diff) ^ overflow; sltu = ~carry-out.
- mul/mulh/mulhu: shift-add, 1 bit per cycle, 2·WIDTH-bit product.
  - mul returns the low half.
  - mulh is signed×signed; mulhu is unsigned×unsigned. Both return the high half.
  - Signed operands are converted to magnitudes, and the product is negated at the end.
- div/divu/mod/modu: restoring division, 1 quotient bit per cycle.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: quotient all-ones, remainder = src1, for both signed and unsigned ops.
  - Signed overflow (src1 = MIN, src2 = -1): quotient MIN, remainder 0.
- All-zero alu_op: result 0, latency 1. Multi-hot alu_op is illegal and undefined; the bench must not drive it.
- flush has priority over everything.
  - Next cycle: state IDLE, out_valid=0, counter cleared.
  - An op offered in the same cycle as flush is not accepted.
- out_valid/alu_result/alu_overflow are stable while out_valid & ~out_ready.

## Timing
- Reset (asynchronous) values: state IDLE, in_ready=1, out_valid=0, alu_result=0, alu_overflow=0, counter=0.
- in_ready is combinational from state and out_ready; there is no path from in_valid.
- Single-cycle op accepted at edge t: out_valid rises after edge t+1, so the result is visible in cycle t+1. Throughput is 1 op/cycle with out_ready held high.
- Iterative op accepted at edge t:
  - BUSY for WIDTH cycles; sign fix-up is folded into the final iteration.
  - out_valid is high in cycle t+WIDTH+1.
- resetn asserted mid-BUSY: immediate IDLE, and no result is produced.
- flush and out_ready high in the same cycle: the result is dropped; both lead to IDLE.

## Structure
- Package alu_pkg holds:
  - Op-bit index constants OP_ADD…OP_MODU and ALU_OP_W=19.
  - State enum {S_IDLE, S_BUSY, S_DONE}.
  - Helper localparam SHW.
- Sub-module alu_muldiv_iter (parameter WIDTH):
  - Ports: start, signed/high/rem select, a, b, busy, done, result.
  - Contains the shared iteration counter, the partial-product/remainder register and the sign fix-up.
- Top level holds the single-cycle combinational ALU, the FSM, the output register and the flush logic.

## Test plan
- WIDTH=32, back-to-back add with out_ready=1:
  - 0x7FFFFFFF+1 → 0x80000000, overflow=1.
  - Next op sltu 1,2 → 1, overflow=0, with no bubble.
- WIDTH=32, mulh of -3 by 5 (0xFFFFFFFD × 5) → 0xFFFFFFFF. out_valid appears exactly 33 cycles after acceptance, and in_ready stays 0 while busy.
- div with src1=0x80000000, src2=0xFFFFFFFF → 0x80000000. mod with the same operands → 0. divu 7/0 → 0xFFFFFFFF. modu 7/0 → 7.
- WIDTH=16: sra 0x8000 by 15 → 0xFFFF; lui src2=0x00AB → 0xAB00; div -7/2 → 0xFFFD; mod -7/2 → 0xFFFF.
- Backpressure: out_ready=0 for 5 cycles after a result. Result and out_valid stay stable, and a new in_valid is not accepted until out_ready=1.
- Cancellation:
  - flush at cycle 10 of a divu → IDLE next cycle, out_valid never rises. A following add 2+3 returns 5.
  - resetn low mid-mul → all outputs return to their reset values immediately.
